// File: rtl/vga_pixel_pipe.sv
// Pixel path from the line buffer to the VGA pins: per-line prefetch requests,
// a 3-edge read/extract pipeline with matched sync/enable delay, and an end-of-frame pulse.
module vga_pixel_pipe #(
    parameter int INTERFACE_WIDTH_BITS = 128,
    parameter int INTERFACE_ADDR_BITS  = 26,
    parameter int BITS_PER_PIXEL       = 16,
    parameter int DISPLAY_WIDTH        = 640,
    parameter int DISPLAY_HEIGHT       = 480,
    parameter int H_TOTAL              = 800,
    parameter int V_TOTAL              = 525,
    parameter int NUM_BUFFER_ENTRIES   = 80,
    parameter int PREFETCH_COL         = 640
) (
    input  logic                            clk_25,
    input  logic                            reset_n,
    input  logic [9:0]                      col,
    input  logic [9:0]                      row,
    input  logic                            de_in,
    input  logic                            hs_in,
    input  logic                            vs_in,
    input  logic [INTERFACE_ADDR_BITS-1:0]  image_base_address,
    output logic                            buffer_start,
    output logic [INTERFACE_ADDR_BITS-1:0]  buffer_base_address,
    output logic [6:0]                      buffer_read_addr,
    input  logic [INTERFACE_WIDTH_BITS-1:0] buffer_read_data,
    output logic [3:0]                      VGA_R,
    output logic [3:0]                      VGA_G,
    output logic [3:0]                      VGA_B,
    output logic                            VGA_HS,
    output logic                            VGA_VS,
    output logic                            end_frame
);
    localparam int LINE_BYTES = DISPLAY_WIDTH * BITS_PER_PIXEL / 8;
    localparam logic [9:0] PREFETCH_C  = 10'(PREFETCH_COL);
    localparam logic [9:0] LAST_ROW    = 10'(V_TOTAL - 1);
    localparam logic [9:0] LAST_VIS    = 10'(DISPLAY_HEIGHT - 1);
    localparam logic [9:0] LAST_COL    = 10'(H_TOTAL - 1);

    logic [INTERFACE_ADDR_BITS-1:0] frame_base_q, frame_base_d;
    logic [INTERFACE_ADDR_BITS-1:0] base_q, base_d;
    logic                           start_q, start_d;
    logic                           end_q, end_d;
    logic [9:0]                     next_row;
    logic                           fetch_hit;

    logic [6:0] rd_addr_q;
    logic [2:0] sel1_q, sel2_q;
    logic       de1_q, de2_q, hs1_q, hs2_q, vs1_q, vs2_q;
    logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       hs_q, vs_q;
    int         pix_lsb;

    always_comb begin
        frame_base_d = frame_base_q;
        if (col == 10'd0 && row == LAST_ROW)
            frame_base_d = image_base_address;

        // Visible rows fetch the following row; the last blanking row fetches row 0 of the next frame.
        fetch_hit = (col == PREFETCH_C) && ((row < LAST_VIS) || (row == LAST_ROW));
        next_row  = (row == LAST_ROW) ? 10'd0 : row + 10'd1;
        start_d   = fetch_hit;
        base_d    = base_q;
        if (fetch_hit)
            base_d = frame_base_q + INTERFACE_ADDR_BITS'(next_row) * INTERFACE_ADDR_BITS'(LINE_BYTES);

        end_d = (col == LAST_COL) && (row == LAST_VIS);

        pix_lsb = int'(sel2_q) * BITS_PER_PIXEL;
        r_d = 4'd0;
        g_d = 4'd0;
        b_d = 4'd0;
        if (de2_q) begin
            r_d = buffer_read_data[pix_lsb + 12 +: 4];
            g_d = buffer_read_data[pix_lsb + 7  +: 4];
            b_d = buffer_read_data[pix_lsb + 1  +: 4];
        end
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            frame_base_q <= '0;
            base_q       <= '0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            rd_addr_q    <= '0;
            sel1_q       <= '0;
            sel2_q       <= '0;
            de1_q        <= 1'b0;
            de2_q        <= 1'b0;
            hs1_q        <= 1'b1;
            hs2_q        <= 1'b1;
            vs1_q        <= 1'b1;
            vs2_q        <= 1'b1;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            frame_base_q <= frame_base_d;
            base_q       <= base_d;
            start_q      <= start_d;
            end_q        <= end_d;
            // E1: address the line buffer, remember which pixel of the entry we want
            rd_addr_q    <= col[9:3];
            sel1_q       <= col[2:0];
            de1_q        <= de_in;
            hs1_q        <= hs_in;
            vs1_q        <= vs_in;
            // E2: buffer data for sel1 becomes valid during this cycle
            sel2_q       <= sel1_q;
            de2_q        <= de1_q;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            // E3: pixel extraction to the pins
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs_q         <= hs2_q;
            vs_q         <= vs2_q;
        end
    end

    assign buffer_start        = start_q;
    assign buffer_base_address = base_q;
    assign buffer_read_addr    = rd_addr_q;
    assign end_frame           = end_q;
    assign VGA_R               = r_q;
    assign VGA_G               = g_q;
    assign VGA_B               = b_q;
    assign VGA_HS              = hs_q;
    assign VGA_VS              = vs_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: line-buffer RAM model, pixel scoreboard, prefetch/frame model,
// constant prefetch vector table and compressed-frame walk.
module tb_vga_pixel_pipe;
    logic        clk_25 = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  col = '0, row = '0;
    logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [25:0] image_base_address = '0;
    logic        buffer_start;
    logic [25:0] buffer_base_address;
    logic [6:0]  buffer_read_addr;
    logic [127:0] rdata = '0;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, end_frame;

    always #20 clk_25 = ~clk_25;

    vga_pixel_pipe dut (
        .clk_25(clk_25), .reset_n(reset_n), .col(col), .row(row),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .image_base_address(image_base_address),
        .buffer_start(buffer_start), .buffer_base_address(buffer_base_address),
        .buffer_read_addr(buffer_read_addr), .buffer_read_data(rdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .end_frame(end_frame)
    );

    // Line buffer: one-cycle synchronous read; out-of-line indices return junk
    localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};
    logic [127:0] mem [0:79];
    always @(posedge clk_25) rdata <= (buffer_read_addr < 7'd80) ? mem[buffer_read_addr] : JUNK;

    int errors = 0, checks = 0;
    int n_start = 0, n_end = 0;
    localparam logic [13:0] RV = 14'h3000;   // {HS=1, VS=1, RGB=0}
    logic [13:0] pq[$];
    logic [25:0] m_frame_base = '0, m_base = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (col=%0d row=%0d)", name, act, exp, col, row);
        end
    endtask

    function automatic logic [13:0] pix_model(input int c, input logic de, input logic hs, input logic vs);
        logic [127:0] entry;
        logic [15:0]  p;
        if (!de) return {hs, vs, 12'h000};
        entry = (c / 8 < 80) ? mem[c / 8] : JUNK;
        p = 16'(entry >> (16 * (c % 8)));
        return {hs, vs, p[15:12], p[10:7], p[4:1]};
    endfunction

    task automatic cyc(input int c, input int r, input logic de, input logic hs, input logic vs, input logic rst);
        logic e_start, e_end;
        logic [6:0] e_addr;
        int nr;
        col = 10'(c); row = 10'(r); de_in = de; hs_in = hs; vs_in = vs; reset_n = !rst;
        if (rst) begin
            e_start = 0; e_end = 0; e_addr = 0;
            m_base = 0; m_frame_base = 0;
            pq.delete(); pq.push_back(RV); pq.push_back(RV);
        end else begin
            e_start = (c == 640) && (r < 479 || r == 524);
            nr = (r == 524) ? 0 : r + 1;
            if (e_start) m_base = m_frame_base + 26'(nr * 1280);
            if (c == 0 && r == 524) m_frame_base = image_base_address;
            e_end = (c == 799) && (r == 479);
            e_addr = 7'(c / 8);
            pq.push_back(pix_model(c, de, hs, vs));
        end
        @(posedge clk_25); #1;
        chk("buffer_start", buffer_start, e_start);
        chk("buffer_base_address", buffer_base_address, m_base);
        chk("end_frame", end_frame, e_end);
        chk("buffer_read_addr", buffer_read_addr, e_addr);
        if (!rst) begin
            if (buffer_start) n_start++;
            if (end_frame) n_end++;
        end
        if (rst) chk("pins_reset", {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, RV);
        else if (pq.size() >= 3) chk("pins", {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, pq.pop_front());
    endtask

    typedef struct {
        int          r;
        logic [25:0] img;
        logic        exp_start;
        logic [25:0] exp_addr;
    } pf_vec_t;
    pf_vec_t tbl[8];

    int walk_cols[10] = '{0, 1, 638, 639, 640, 641, 642, 797, 798, 799};

    initial begin
        tbl[0] = '{5,   26'h0000000, 1'b1, 26'h0001E00};
        tbl[1] = '{0,   26'h0000000, 1'b1, 26'h0000500};
        tbl[2] = '{478, 26'h0000000, 1'b1, 26'h0095B00};
        tbl[3] = '{479, 26'h0000000, 1'b0, 26'h0000000};
        tbl[4] = '{523, 26'h0000000, 1'b0, 26'h0000000};
        tbl[5] = '{524, 26'h004B000, 1'b1, 26'h004B000};
        tbl[6] = '{10,  26'h004B000, 1'b1, 26'h004E700};
        tbl[7] = '{478, 26'h3FFFF00, 1'b1, 26'h0095A00};

        for (int i = 0; i < 80; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = {16'hF800, 16'h07E0, 16'hFFFF, 16'h8410, 16'h0000, 16'hF81F, 16'h1234, 16'h001F};

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1);

        // Column sweep over entry 0: col0 -> blue, col7 -> red, three edges later
        for (int c = 0; c < 10; c++) begin
            cyc(c, 0, 1, 1, 1, 0);
            if (c == 2) begin
                chk("col0_R", VGA_R, 4'h0); chk("col0_G", VGA_G, 4'h0); chk("col0_B", VGA_B, 4'hF);
            end
            if (c == 9) begin
                chk("col7_R", VGA_R, 4'hF); chk("col7_G", VGA_G, 4'h0); chk("col7_B", VGA_B, 4'h0);
            end
        end

        // Prefetch vector table
        for (int i = 0; i < 8; i++) begin
            image_base_address = tbl[i].img;
            cyc(0, 524, 0, 1, 1, 0);
            cyc(640, tbl[i].r, 0, 1, 1, 0);
            chk("tbl_start", buffer_start, tbl[i].exp_start);
            if (tbl[i].exp_start) chk("tbl_addr", buffer_base_address, tbl[i].exp_addr);
            cyc(641, tbl[i].r, 0, 1, 1, 0);
            chk("tbl_pulse_width", buffer_start, 1'b0);
        end

        // Reset held 5 cycles mid-line, then clean restart
        for (int c = 100; c < 120; c++) cyc(c, 10, 1, 1, 1, 0);
        for (int c = 120; c < 125; c++) begin
            cyc(c, 10, 1, 0, 0, 1);
            chk("rst_start", buffer_start, 1'b0);
        end
        for (int c = 125; c < 140; c++) cyc(c, 10, 1, 1, 1, 0);

        // Randomized timing inputs, sync/enable toggles, occasional reset
        for (int i = 0; i < 800; i++) begin
            int c, r;
            c = $urandom_range(0, 799);
            r = $urandom_range(0, 524);
            if ($urandom_range(0, 19) == 0) image_base_address = 26'($urandom);
            cyc(c, r, (c < 640 && r < 480) ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 59) == 0));
        end

        // Compressed frame walk: event columns of every row; image base changes mid-frame
        image_base_address = 26'h0123400;
        foreach (walk_cols[k]) cyc(walk_cols[k], 524, 0, 1, 1, 0);
        n_start = 0; n_end = 0;
        for (int r = 0; r < 525; r++) begin
            if (r == 200) image_base_address = 26'h2ABC000;
            foreach (walk_cols[k]) begin
                cyc(walk_cols[k], r, (walk_cols[k] < 640 && r < 480), 1'b1, !(r == 490 || r == 491), 1'b0);
                if (r == 300 && walk_cols[k] == 640)
                    chk("no_tear", buffer_base_address, 26'h0123400 + 26'(301 * 1280));
            end
        end
        chk("start_count", n_start, 480);
        chk("end_count", n_end, 1);
        chk("next_frame_base", buffer_base_address, 26'h2ABC000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
